// File: rtl/riscv_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_ctrl_pkg
// Description : Shared definitions for the multicycle RV32I control unit.
//               It holds the FSM state encoding, the opcode constants, the
//               datapath select codes and the ALU control codes.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_JAL      = 4'd9,
        S_BEQ      = 4'd10
    } state_t;

    // Opcodes
    localparam logic [6:0] C_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] C_OP_STORE  = 7'b0100011;
    localparam logic [6:0] C_OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] C_OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] C_OP_JAL    = 7'b1101111;
    localparam logic [6:0] C_OP_BRANCH = 7'b1100011;

    // result_src
    localparam logic [1:0] C_RES_ALUOUT  = 2'b00;
    localparam logic [1:0] C_RES_MEMDATA = 2'b01;
    localparam logic [1:0] C_RES_ALURES  = 2'b10;

    // alu_src_a
    localparam logic [1:0] C_SRCA_PC    = 2'b00;
    localparam logic [1:0] C_SRCA_OLDPC = 2'b01;
    localparam logic [1:0] C_SRCA_REGA  = 2'b10;

    // alu_src_b
    localparam logic [1:0] C_SRCB_REGB  = 2'b00;
    localparam logic [1:0] C_SRCB_IMM   = 2'b01;
    localparam logic [1:0] C_SRCB_FOUR  = 2'b10;

    // imm_src
    localparam logic [1:0] C_IMM_I = 2'b00;
    localparam logic [1:0] C_IMM_S = 2'b01;
    localparam logic [1:0] C_IMM_B = 2'b10;
    localparam logic [1:0] C_IMM_J = 2'b11;

    // alu_op (internal between FSM and ALU decoder)
    localparam logic [1:0] C_ALUOP_ADD   = 2'b00;
    localparam logic [1:0] C_ALUOP_SUB   = 2'b01;
    localparam logic [1:0] C_ALUOP_FUNCT = 2'b10;

    // alu_control
    localparam logic [2:0] C_ALU_ADD = 3'b000;
    localparam logic [2:0] C_ALU_SUB = 3'b001;
    localparam logic [2:0] C_ALU_AND = 3'b010;
    localparam logic [2:0] C_ALU_OR  = 3'b011;
    localparam logic [2:0] C_ALU_XOR = 3'b100;
    localparam logic [2:0] C_ALU_SLT = 3'b101;

endpackage
`default_nettype wire

// File: rtl/alu_decoder.sv
`default_nettype none
// ============================================================================
// Module      : alu_decoder
// Description : Maps the FSM's ALU operation class and the instruction
//               function fields to an ALU control code.
//   alu_op      in  2  00 add, 01 sub, 10 decode from funct3
//   funct3      in  3  instr[14:12]
//   op5         in  1  instr[5], distinguishes R-type from I-type
//   funct7b5    in  1  instr[30]
//   alu_control out 3  ALU operation code
// Revision    : 1.0 - initial release
// ============================================================================
module alu_decoder
    import riscv_ctrl_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic       op5,
    input  logic       funct7b5,
    output logic [2:0] alu_control
);

    always_comb begin
        alu_control = C_ALU_ADD;
        case (alu_op)
            C_ALUOP_ADD: alu_control = C_ALU_ADD;
            C_ALUOP_SUB: alu_control = C_ALU_SUB;
            C_ALUOP_FUNCT: begin
                case (funct3)
                    // funct7b5 is part of the immediate on I-type (addi),
                    // so subtract only when the instruction is R-type.
                    3'b000:  alu_control = (op5 & funct7b5) ? C_ALU_SUB : C_ALU_ADD;
                    3'b100:  alu_control = C_ALU_XOR;
                    3'b010:  alu_control = C_ALU_SLT;
                    3'b110:  alu_control = C_ALU_OR;
                    3'b111:  alu_control = C_ALU_AND;
                    default: alu_control = C_ALU_ADD;
                endcase
            end
            default: alu_control = C_ALU_ADD;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_control
// Description : Moore FSM controller for the multicycle RV32I datapath.
//               It drives all mux selects, the write enables and the ALU
//               control code.
//   clk, reset          clock, asynchronous active-high reset
//   op/funct3/funct7b5  instruction fields from the instruction register
//   zero                ALU zero flag (used in BEQ only)
//   pc_write, ir_write, mem_write, reg_write   write enables
//   adr_src, result_src, alu_src_a, alu_src_b, imm_src   mux selects
//   alu_control         ALU operation code
//   illegal_instr       one-cycle pulse in DECODE on an unsupported opcode
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_control
    import riscv_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    output logic       pc_write,
    output logic       adr_src,
    output logic       mem_write,
    output logic       ir_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] imm_src,
    output logic [2:0] alu_control,
    output logic       reg_write,
    output logic       illegal_instr
);

    state_t     state_q;
    state_t     state_d;

    logic       w_pc_update;
    logic       w_branch;
    logic       w_mem_write;
    logic       w_ir_write;
    logic       w_reg_write;
    logic       w_illegal;
    logic [1:0] w_alu_op;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = S_FETCH;
        w_pc_update = 1'b0;
        w_branch    = 1'b0;
        w_mem_write = 1'b0;
        w_ir_write  = 1'b0;
        w_reg_write = 1'b0;
        w_illegal   = 1'b0;
        w_alu_op    = C_ALUOP_ADD;
        adr_src     = 1'b0;
        result_src  = C_RES_ALUOUT;
        alu_src_a   = C_SRCA_PC;
        alu_src_b   = C_SRCB_REGB;

        case (state_q)
            S_FETCH: begin
                w_ir_write  = 1'b1;
                w_pc_update = 1'b1;
                alu_src_b   = C_SRCB_FOUR;
                result_src  = C_RES_ALURES;
                state_d     = S_DECODE;
            end
            S_DECODE: begin
                // Branch/jump target is computed here from OldPC + imm.
                alu_src_a = C_SRCA_OLDPC;
                alu_src_b = C_SRCB_IMM;
                case (op)
                    C_OP_LOAD,
                    C_OP_STORE:  state_d = S_MEMADR;
                    C_OP_RTYPE:  state_d = S_EXECUTER;
                    C_OP_ITYPE:  state_d = S_EXECUTEI;
                    C_OP_JAL:    state_d = S_JAL;
                    C_OP_BRANCH: state_d = S_BEQ;
                    default: begin
                        state_d   = S_FETCH;
                        w_illegal = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a = C_SRCA_REGA;
                alu_src_b = C_SRCB_IMM;
                state_d   = op[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                adr_src = 1'b1;
                state_d = S_MEMWB;
            end
            S_MEMWB: begin
                result_src  = C_RES_MEMDATA;
                w_reg_write = 1'b1;
                state_d     = S_FETCH;
            end
            S_MEMWRITE: begin
                adr_src     = 1'b1;
                w_mem_write = 1'b1;
                state_d     = S_FETCH;
            end
            S_EXECUTER: begin
                alu_src_a = C_SRCA_REGA;
                w_alu_op  = C_ALUOP_FUNCT;
                state_d   = S_ALUWB;
            end
            S_EXECUTEI: begin
                alu_src_a = C_SRCA_REGA;
                alu_src_b = C_SRCB_IMM;
                w_alu_op  = C_ALUOP_FUNCT;
                state_d   = S_ALUWB;
            end
            S_ALUWB: begin
                w_reg_write = 1'b1;
                state_d     = S_FETCH;
            end
            S_JAL: begin
                // PC <- target (ALUOut from DECODE); ALU forms OldPC + 4.
                alu_src_a   = C_SRCA_OLDPC;
                alu_src_b   = C_SRCB_FOUR;
                w_pc_update = 1'b1;
                state_d     = S_ALUWB;
            end
            S_BEQ: begin
                alu_src_a = C_SRCA_REGA;
                w_alu_op  = C_ALUOP_SUB;
                w_branch  = 1'b1;
                state_d   = S_FETCH;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // funct3[0] inverts the sense of zero: 000 = beq, 001 = bne.
    // Write enables are suppressed while reset is held so an abandoned
    // instruction cannot touch architectural state.
    assign pc_write      = ~reset & (w_pc_update | (w_branch & (zero ^ funct3[0])));
    assign ir_write      = ~reset & w_ir_write;
    assign mem_write     = ~reset & w_mem_write;
    assign reg_write     = ~reset & w_reg_write;
    assign illegal_instr = ~reset & w_illegal;

    always_comb begin
        imm_src = C_IMM_I;
        case (op)
            C_OP_LOAD,
            C_OP_ITYPE:  imm_src = C_IMM_I;
            C_OP_STORE:  imm_src = C_IMM_S;
            C_OP_BRANCH: imm_src = C_IMM_B;
            C_OP_JAL:    imm_src = C_IMM_J;
            default:     imm_src = C_IMM_I;
        endcase
    end

    alu_decoder u_alu_decoder (
        .alu_op      (w_alu_op),
        .funct3      (funct3),
        .op5         (op[5]),
        .funct7b5    (funct7b5),
        .alu_control (alu_control)
    );

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_control
// Description : Self-checking bench for multicycle_control. A cycle-indexed
//               reference model gives the expected control word for every
//               cycle of every instruction class.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_control;

    logic       clk;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       pc_write, adr_src, mem_write, ir_write, reg_write, illegal_instr;
    logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
    logic [2:0] alu_control;

    int tests_run = 0;
    int tests_failed = 0;

    multicycle_control dut (
        .clk           (clk),
        .reset         (reset),
        .op            (op),
        .funct3        (funct3),
        .funct7b5      (funct7b5),
        .zero          (zero),
        .pc_write      (pc_write),
        .adr_src       (adr_src),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .result_src    (result_src),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .imm_src       (imm_src),
        .alu_control   (alu_control),
        .reg_write     (reg_write),
        .illegal_instr (illegal_instr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed control word:
    // {pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
    //  alu_src_b, imm_src, alu_control, reg_write, illegal_instr}
    function automatic logic [17:0] pack(input logic pcw, input logic adr,
                                         input logic mw, input logic irw,
                                         input logic [1:0] rs, input logic [1:0] a,
                                         input logic [1:0] b, input logic [1:0] imm,
                                         input logic [2:0] ctl, input logic rw,
                                         input logic ill);
        return {pcw, adr, mw, irw, rs, a, b, imm, ctl, rw, ill};
    endfunction

    wire [17:0] observed = {pc_write, adr_src, mem_write, ir_write, result_src,
                            alu_src_a, alu_src_b, imm_src, alu_control,
                            reg_write, illegal_instr};

    // Instruction classes
    localparam int K_LW = 0, K_SW = 1, K_R = 2, K_I = 3, K_JAL = 4, K_BR = 5, K_ILL = 6;

    function automatic int kind_of(input logic [6:0] o);
        case (o)
            7'b0000011: return K_LW;
            7'b0100011: return K_SW;
            7'b0110011: return K_R;
            7'b0010011: return K_I;
            7'b1101111: return K_JAL;
            7'b1100011: return K_BR;
            default:    return K_ILL;
        endcase
    endfunction

    function automatic int cpi(input logic [6:0] o);
        int t[7] = '{5, 4, 4, 4, 4, 3, 2};
        return t[kind_of(o)];
    endfunction

    function automatic logic [1:0] imm_of(input logic [6:0] o);
        case (kind_of(o))
            K_SW:    return 2'b01;
            K_BR:    return 2'b10;
            K_JAL:   return 2'b11;
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic [2:0] func_alu(input logic [2:0] f3, input logic sub);
        case (f3)
            3'd0:    return sub ? 3'b001 : 3'b000;
            3'd4:    return 3'b100;
            3'd2:    return 3'b101;
            3'd6:    return 3'b011;
            3'd7:    return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    // Expected control word for cycle c (0 = fetch) of the given instruction.
    function automatic logic [17:0] model(input logic [6:0] o, input logic [2:0] f3,
                                          input logic f7, input logic z, input int c);
        logic pcw = 0, adr = 0, mw = 0, irw = 0, rw = 0, ill = 0;
        logic [1:0] rs = 0, a = 0, b = 0;
        logic [2:0] ctl = 0;
        int k = kind_of(o);
        if (c == 0) begin
            irw = 1; pcw = 1; b = 2'b10; rs = 2'b10;
        end else if (c == 1) begin
            a = 2'b01; b = 2'b01; ill = (k == K_ILL);
        end else begin
            case (k)
                K_LW: begin
                    if (c == 2) begin a = 2'b10; b = 2'b01; end
                    if (c == 3) adr = 1;
                    if (c == 4) begin rs = 2'b01; rw = 1; end
                end
                K_SW: begin
                    if (c == 2) begin a = 2'b10; b = 2'b01; end
                    if (c == 3) begin adr = 1; mw = 1; end
                end
                K_R: begin
                    if (c == 2) begin a = 2'b10; ctl = func_alu(f3, f7); end
                    if (c == 3) rw = 1;
                end
                K_I: begin
                    if (c == 2) begin a = 2'b10; b = 2'b01; ctl = func_alu(f3, 1'b0); end
                    if (c == 3) rw = 1;
                end
                K_JAL: begin
                    if (c == 2) begin a = 2'b01; b = 2'b10; pcw = 1; end
                    if (c == 3) rw = 1;
                end
                K_BR: begin
                    a = 2'b10; ctl = 3'b001; pcw = z ^ f3[0];
                end
                default: ;
            endcase
        end
        return pack(pcw, adr, mw, irw, rs, a, b, imm_of(o), ctl, rw, ill);
    endfunction

    task automatic check(input string tag, input logic [17:0] exp);
        tests_run++;
        assert (observed === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%b expected=%b op=%b f3=%b f7=%b z=%b",
                   tag, observed, exp, op, funct3, funct7b5, zero);
        end
    endtask

    // Runs one instruction starting in FETCH, just after a clock edge.
    // zmode: 0/1 forces zero, 2 randomises it every cycle.
    // abort_at >= 0 asserts reset during that cycle and abandons the instruction.
    task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                             input int zmode, input int abort_at, input string tag);
        logic [17:0] rst_word;
        op = o; funct3 = f3; funct7b5 = f7;
        rst_word = pack(0, 0, 0, 0, 2'b10, 2'b00, 2'b10, imm_of(o), 3'b000, 0, 0);
        for (int c = 0; c < cpi(o); c++) begin
            zero = (zmode == 2) ? 1'($urandom_range(0, 1)) : 1'(zmode);
            #1;
            check($sformatf("%s_c%0d", tag, c), model(o, f3, f7, zero, c));
            if (c == abort_at) begin
                #1 reset = 1'b1;
                #1 check($sformatf("%s_rst_async", tag), rst_word);
                @(posedge clk);
                #1 check($sformatf("%s_rst_held", tag), rst_word);
                reset = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [6:0] rop;
        logic [31:0] rnd;
        logic [6:0] ops[6] = '{7'b0000011, 7'b0100011, 7'b0110011,
                                7'b0010011, 7'b1101111, 7'b1100011};

        reset = 1'b1; op = 7'b0000011; funct3 = 3'b000; funct7b5 = 1'b0; zero = 1'b0;
        #2 check("reset_early", pack(0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 0, 0));
        @(posedge clk);
        #2 check("reset_held", pack(0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 0, 0));
        reset = 1'b0;

        // Directed instructions
        run_instr(7'b0000011, 3'b010, 1'b0, 2, -1, "lw");
        run_instr(7'b0100011, 3'b010, 1'b0, 2, -1, "sw");
        run_instr(7'b1100011, 3'b000, 1'b0, 1, -1, "beq_z1");
        run_instr(7'b1100011, 3'b000, 1'b0, 0, -1, "beq_z0");
        run_instr(7'b1100011, 3'b001, 1'b0, 0, -1, "bne_z0");
        run_instr(7'b1100011, 3'b001, 1'b0, 1, -1, "bne_z1");
        run_instr(7'b0110011, 3'b000, 1'b1, 2, -1, "r_sub");
        run_instr(7'b0110011, 3'b111, 1'b0, 2, -1, "r_and");
        run_instr(7'b0010011, 3'b000, 1'b1, 2, -1, "i_addi_f7");
        run_instr(7'b0010011, 3'b110, 1'b0, 2, -1, "i_ori");
        run_instr(7'b1101111, 3'b000, 1'b0, 2, -1, "jal");
        run_instr(7'b1111111, 3'b000, 1'b0, 2, -1, "illegal");
        run_instr(7'b0000011, 3'b010, 1'b0, 2, 3, "lw_abort");
        run_instr(7'b0000011, 3'b010, 1'b0, 2, -1, "lw_after_abort");

        // Randomised instruction stream
        for (int n = 0; n < 300; n++) begin
            rnd = $urandom;
            if (rnd[2:0] == 3'd6 || rnd[2:0] == 3'd7) rop = rnd[15:9];
            else rop = ops[rnd[2:0]];
            run_instr(rop, rnd[18:16], rnd[19], 2,
                      (rnd[27:20] == 8'd0) ? 2 : -1, "rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
